// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative signed mult/div.
// Hi carries the product upper word or the division remainder.
module alu_multiciclo #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Inicio,
   input  logic [5:0]       ALU_Ctrl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Ocupado,
   output logic             Pronto,
   output logic [WIDTH-1:0] Resultado,
   output logic [WIDTH-1:0] Hi,
   output logic             Zero,
   output logic             Div_Zero,
   output logic             Invalido
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   localparam logic [5:0] OpAdd  = 6'b000000;
   localparam logic [5:0] OpSub  = 6'b000001;
   localparam logic [5:0] OpMult = 6'b000010;
   localparam logic [5:0] OpDiv  = 6'b000011;
   localparam logic [5:0] OpOr   = 6'b000100;
   localparam logic [5:0] OpAnd  = 6'b000101;
   localparam logic [5:0] OpNot  = 6'b000110;
   localparam logic [5:0] OpSlt  = 6'b000111;
   localparam logic [5:0] OpSle  = 6'b100100;
   localparam logic [5:0] OpSge  = 6'b100101;

   typedef enum logic [1:0] {StOcioso, StMult, StDiv, StAjuste} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0]  opnd_q, opnd_d;
   logic              is_div_q, is_div_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic              ocupado_q, ocupado_d;
   logic              pronto_q, pronto_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic              zero_q, zero_d;
   logic              div_zero_q, div_zero_d;
   logic              invalido_q, invalido_d;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mult_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] prod_mag, prod_sgn;
   logic [WIDTH-1:0]   op_res;
   logic               op_inv;

   // Single-cycle operation results
   always_comb begin
      op_res = '0;
      op_inv = 1'b0;
      case (ALU_Ctrl)
         OpAdd:   op_res = A + B;
         OpSub:   op_res = A - B;
         OpOr:    op_res = A | B;
         OpAnd:   op_res = A & B;
         OpNot:   op_res = ~A;
         OpSlt:   op_res = {{(WIDTH-1){1'b0}}, $signed(A) <  $signed(B)};
         OpSle:   op_res = {{(WIDTH-1){1'b0}}, $signed(A) <= $signed(B)};
         OpSge:   op_res = {{(WIDTH-1){1'b0}}, $signed(A) >= $signed(B)};
         default: op_inv = 1'b1;
      endcase
   end

   always_comb begin
      a_mag = A[WIDTH-1] ? -A : A;
      b_mag = B[WIDTH-1] ? -B : B;
      // Shift-add: multiplier sits in acc_lo and drains out the bottom
      mult_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
      // Restoring division: remainder in acc_hi, quotient shifts into acc_lo
      div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_ge = div_shift >= {1'b0, opnd_q};
      div_rem = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
      prod_mag = {acc_hi_q, acc_lo_q};
      prod_sgn = neg_res_q ? -prod_mag : prod_mag;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      opnd_d     = opnd_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      ocupado_d  = ocupado_q;
      pronto_d   = 1'b0;
      res_d      = res_q;
      hi_d       = hi_q;
      div_zero_d = div_zero_q;
      invalido_d = invalido_q;

      unique case (state_q)
         StOcioso: begin
            if (Inicio) begin
               cnt_d = '0;
               if (ALU_Ctrl == OpMult) begin
                  state_d   = StMult;
                  ocupado_d = 1'b1;
                  acc_hi_d  = '0;
                  acc_lo_d  = b_mag;
                  opnd_d    = a_mag;
                  is_div_d  = 1'b0;
                  neg_res_d = A[WIDTH-1] ^ B[WIDTH-1];
                  neg_rem_d = 1'b0;
               end else if (ALU_Ctrl == OpDiv && B != '0) begin
                  state_d   = StDiv;
                  ocupado_d = 1'b1;
                  acc_hi_d  = '0;
                  acc_lo_d  = a_mag;
                  opnd_d    = b_mag;
                  is_div_d  = 1'b1;
                  neg_res_d = A[WIDTH-1] ^ B[WIDTH-1];
                  neg_rem_d = A[WIDTH-1];
               end else if (ALU_Ctrl == OpDiv) begin
                  pronto_d   = 1'b1;
                  res_d      = '0;
                  hi_d       = A;
                  div_zero_d = 1'b1;
                  invalido_d = 1'b0;
               end else begin
                  pronto_d   = 1'b1;
                  res_d      = op_res;
                  hi_d       = '0;
                  div_zero_d = 1'b0;
                  invalido_d = op_inv;
               end
            end
         end
         StMult: begin
            cnt_d    = cnt_q + CntW'(1);
            acc_hi_d = mult_sum[WIDTH:1];
            acc_lo_d = {mult_sum[0], acc_lo_q[WIDTH-1:1]};
            if (cnt_d == CntW'(WIDTH)) state_d = StAjuste;
         end
         StDiv: begin
            cnt_d    = cnt_q + CntW'(1);
            acc_hi_d = div_rem;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
            if (cnt_d == CntW'(WIDTH)) state_d = StAjuste;
         end
         StAjuste: begin
            state_d    = StOcioso;
            ocupado_d  = 1'b0;
            pronto_d   = 1'b1;
            div_zero_d = 1'b0;
            invalido_d = 1'b0;
            if (is_div_q) begin
               res_d = neg_res_q ? -acc_lo_q : acc_lo_q;
               hi_d  = neg_rem_q ? -acc_hi_q : acc_hi_q;
            end else begin
               res_d = prod_sgn[WIDTH-1:0];
               hi_d  = prod_sgn[2*WIDTH-1:WIDTH];
            end
         end
         default: state_d = StOcioso;
      endcase

      zero_d = (res_d == '0);
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q    <= StOcioso;
         cnt_q      <= '0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         opnd_q     <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         ocupado_q  <= 1'b0;
         pronto_q   <= 1'b0;
         res_q      <= '0;
         hi_q       <= '0;
         zero_q     <= 1'b0;
         div_zero_q <= 1'b0;
         invalido_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         opnd_q     <= opnd_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         ocupado_q  <= ocupado_d;
         pronto_q   <= pronto_d;
         res_q      <= res_d;
         hi_q       <= hi_d;
         zero_q     <= zero_d;
         div_zero_q <= div_zero_d;
         invalido_q <= invalido_d;
      end
   end

   assign Ocupado   = ocupado_q;
   assign Pronto    = pronto_q;
   assign Resultado = res_q;
   assign Hi        = hi_q;
   assign Zero      = zero_q;
   assign Div_Zero  = div_zero_q;
   assign Invalido  = invalido_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Scoreboard bench for alu_multiciclo: stimulus pushes expectations, a
// monitor pops and compares on every Pronto pulse.
module tb_alu_multiciclo;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          inicio;
   logic [5:0]    alu_ctrl;
   logic [W-1:0]  a, b;
   logic          ocupado, pronto, zero, div_zero, invalido;
   logic [W-1:0]  resultado, hi;

   alu_multiciclo #(.WIDTH(W)) dut (
      .Clock     (clk),
      .Reset     (rst),
      .Inicio    (inicio),
      .ALU_Ctrl  (alu_ctrl),
      .A         (a),
      .B         (b),
      .Ocupado   (ocupado),
      .Pronto    (pronto),
      .Resultado (resultado),
      .Hi        (hi),
      .Zero      (zero),
      .Div_Zero  (div_zero),
      .Invalido  (invalido)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic        zero;
      logic        dz;
      logic        inv;
      int unsigned acc;
      int unsigned delta;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int unsigned cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (pronto) begin
         if (sb.size() == 0) begin
            chk("unexpected Pronto", 64'(pronto), 64'(0));
         end else begin
            e = sb.pop_front();
            chk({e.name, " Resultado"}, 64'(resultado), 64'(e.res));
            chk({e.name, " Hi"}, 64'(hi), 64'(e.hi));
            chk({e.name, " Zero"}, 64'(zero), 64'(e.zero));
            chk({e.name, " Div_Zero"}, 64'(div_zero), 64'(e.dz));
            chk({e.name, " Invalido"}, 64'(invalido), 64'(e.inv));
            chk({e.name, " latency"}, 64'(cyc - e.acc), 64'(e.delta));
         end
      end
   end

   task automatic issue(input string name, input logic [5:0] op, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic [W-1:0] res, input logic [W-1:0] h,
                        input logic dz, input logic inv, input int unsigned delta,
                        input bit push);
      int k = 0;
      exp_t x;
      @(negedge clk);
      while (ocupado && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (ocupado) chk({name, " busy timeout"}, 64'(ocupado), 64'(0));
      inicio   = 1'b1;
      alu_ctrl = op;
      a        = ia;
      b        = ib;
      @(posedge clk);
      #1;
      inicio = 1'b0;
      if (push) begin
         x.name  = name;
         x.res   = res;
         x.hi    = h;
         x.zero  = (res == '0);
         x.dz    = dz;
         x.inv   = inv;
         x.acc   = cyc;
         x.delta = delta;
         sb.push_back(x);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {ocupado, pronto, zero, div_zero, invalido, resultado ^ hi,
              27'(resultado != 0 || hi != 0)};
   endfunction

   initial begin
      int busy_cnt;
      int k;
      rst = 1'b1;
      inicio = 1'b0;
      alu_ctrl = '0;
      a = '0;
      b = '0;
      #1;
      chk("reset outputs", all_outs(), 64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single-cycle ops, issued back-to-back
      issue("add ovf",  6'b000000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 0, 0, 1);
      issue("sub zero", 6'b000001, 32'h5, 32'h5, 32'h0, 0, 0, 0, 0, 1);
      issue("slt neg",  6'b000111, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 0, 0, 1);
      issue("sle neg",  6'b100100, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 0, 0, 1);
      issue("sge neg",  6'b100101, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0, 0, 0, 1);
      issue("slt eq",   6'b000111, 32'h3, 32'h3, 32'h0, 0, 0, 0, 0, 1);
      issue("sle eq",   6'b100100, 32'h3, 32'h3, 32'h1, 0, 0, 0, 0, 1);
      issue("sge eq",   6'b100101, 32'h3, 32'h3, 32'h1, 0, 0, 0, 0, 1);
      issue("or",       6'b000100, 32'hF0, 32'h0F, 32'hFF, 0, 0, 0, 0, 1);
      issue("and",      6'b000101, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 0, 0, 0, 0, 1);
      issue("not",      6'b000110, 32'h0, 32'h12345678, 32'hFFFFFFFF, 0, 0, 0, 0, 1);

      // mult -3*7 with add pulses and operand churn while busy
      issue("mult neg", 6'b000010, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 32'hFFFFFFFF,
            0, 0, W + 1, 1);
      busy_cnt = 0;
      k = 0;
      while (k < 100) begin
         @(negedge clk);
         k++;
         if (!ocupado) break;
         busy_cnt++;
         inicio   = (busy_cnt >= 3 && busy_cnt <= 6);
         alu_ctrl = 6'b000000;
         a        = $urandom;
         b        = $urandom;
      end
      inicio = 1'b0;
      chk("mult Ocupado cycles", 64'(busy_cnt), 64'(W + 1));

      issue("mult minneg", 6'b000010, 32'h80000000, 32'h80000000, 32'h0, 32'h40000000,
            0, 0, W + 1, 1);
      issue("div neg",   6'b000011, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF,
            0, 0, W + 1, 1);
      issue("div by 0",  6'b000011, 32'h5, 32'h0, 32'h0, 32'h5, 1, 0, 0, 1);
      issue("div ovf",   6'b000011, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,
            0, 0, W + 1, 1);
      issue("div pos",   6'b000011, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, W + 1, 1);
      issue("div negb",  6'b000011, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1, 0, 0, W + 1, 1);
      issue("invalid",   6'b111111, 32'h1234, 32'h5678, 32'h0, 32'h0, 0, 1, 0, 1);
      issue("add after inv", 6'b000000, 32'h1, 32'h1, 32'h2, 32'h0, 0, 0, 0, 1);

      // Reset 10 cycles into a mult: no Pronto may follow
      issue("mult abort", 6'b000010, 32'h1234, 32'h5678, 0, 0, 0, 0, 0, 0);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("reset mid-mult outputs", all_outs(), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      issue("add post-reset", 6'b000000, 32'h2, 32'h3, 32'h5, 32'h0, 0, 0, 0, 1);

      k = 0;
      while (sb.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("scoreboard drained", 64'(sb.size()), 64'(0));
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_multiciclo.md
# alu_multiciclo

Multi-cycle ALU that executes the 6-bit `ALU_Ctrl` operation codes produced by the ALU control decoder, in the datapath execute stage. Single-cycle operations return a result one cycle after start. Signed `mult` and `div` run an iterative shift-add / shift-subtract engine under a start/busy/done handshake. `Hi` carries the product upper word or the division remainder.

## Interface
- `WIDTH`, default 32: operand and result width in bits, minimum 4.
- `Clock`, in, 1: rising-edge clock.
- `Reset`, in, 1: asynchronous, active-high.
- `Inicio`, in, 1: start request. Sampled only when `Ocupado`=0.
- `ALU_Ctrl`, in, 6: operation code, latched at accept.
- `A`, in, WIDTH: operand A, latched at accept.
- `B`, in, WIDTH: operand B, latched at accept.
- `Ocupado`, out, 1: engine busy with `mult`/`div`.
- `Pronto`, out, 1: one-cycle pulse marking `Resultado`/`Hi`/flags valid.
- `Resultado`, out, WIDTH: result, or product low word / quotient.
- `Hi`, out, WIDTH: product high word / remainder. 0 for all other operations.
- `Zero`, out, 1: `Resultado`==0, registered with the result.
- `Div_Zero`, out, 1: `div` with B==0.
- `Invalido`, out, 1: unrecognised `ALU_Ctrl` code.

## Operation
- Opcodes:
  - 000000 add: A+B.
  - 000001 sub: A−B.
  - 000010 mult: signed A×B.
  - 000011 div: signed A/B.
  - 000100 or.
  - 000101 and.
  - 000110 not: ~A, B ignored.
  - 000111 slt: signed A<B.
  - 100100 sle: signed A<=B.
  - 100101 sge: signed A>=B.
- add/sub wrap modulo 2^WIDTH. No overflow flag.
- slt/sle/sge: `Resultado` = {0…0, bit}.
- mult: full 2·WIDTH signed product. `Hi` = upper word, `Resultado` = lower word.
  - Engine works on operand magnitudes, one bit per cycle, WIDTH iterations.
  - Sign is applied in the AJUSTE state.
- div: quotient truncates toward zero. Remainder takes the sign of A.
  - Most-negative / −1 gives quotient = most-negative and remainder 0. No flag.
- div with B==0: completes as a single-cycle op with `Resultado`=0, `Hi`=A, `Div_Zero`=1.
- Any other code: single-cycle op with `Resultado`=0, `Hi`=0, `Invalido`=1.
- `Div_Zero` and `Invalido` are 0 for every other operation.
- FSM states:
  - OCIOSO → MULT on accept of mult.
  - OCIOSO → DIV on accept of div with B≠0.
  - OCIOSO → OCIOSO on accept of any single-cycle op, or with no accept.
  - MULT/DIV → AJUSTE when the iteration counter reaches WIDTH.
  - AJUSTE → OCIOSO unconditionally, asserting `Pronto`.
- Iteration counter is $clog2(WIDTH)+1 bits. Cleared on accept, incremented once per MULT/DIV cycle.
- Outputs hold their last values until the next completion, except `Pronto`.

## Timing
- Reset, asynchronous: FSM=OCIOSO, counter=0, and `Ocupado`, `Pronto`, `Resultado`, `Hi`, `Zero`, `Div_Zero`, `Invalido` all 0.
- Reset mid-operation aborts the operation with no `Pronto`. The first edge after release may accept.
- Accept happens at a rising edge with `Inicio`=1 and `Ocupado`=0. Call it edge 0.
- Single-cycle ops: results and `Pronto`=1 are registered at edge 0 and visible in cycle 1. Latency 1. `Ocupado` stays 0.
- mult/div: `Ocupado`=1 after edge 0.
  - Edges 1..WIDTH iterate.
  - Edge WIDTH+1 is AJUSTE: results registered, `Pronto`=1, `Ocupado`=0.
  - Latency WIDTH+1 cycles.
- `Inicio` while `Ocupado`=1 is ignored, not queued.
- Back-to-back operation: `Inicio` during the `Pronto` cycle is accepted at the next edge.
- `A`, `B`, `ALU_Ctrl` changes after accept have no effect.
- `Pronto` is exactly one cycle wide.

## Test plan
- Add and sub:
  - add A=7FFFFFFF, B=1 → `Resultado`=80000000, `Zero`=0, `Pronto` in cycle 1.
  - sub A=5, B=5 → `Resultado`=0, `Zero`=1.
- Signed compares:
  - A=FFFFFFFF, B=1 → slt=1, sle=1, sge=0.
  - A=B=3 → slt=0, sle=1, sge=1.
- mult A=FFFFFFFD (−3), B=7 → `Resultado`=FFFFFFEB, `Hi`=FFFFFFFF. `Ocupado` high 33 cycles, `Pronto` exactly 33 cycles after accept. `Inicio` pulses with opcode add while busy → ignored.
- div cases:
  - A=FFFFFFF9 (−7), B=2 → `Resultado`=FFFFFFFD, `Hi`=FFFFFFFF.
  - A=5, B=0 → `Pronto` in cycle 1, `Div_Zero`=1, `Resultado`=0, `Hi`=5.
  - A=80000000, B=FFFFFFFF → `Resultado`=80000000, `Hi`=0.
- `Reset` pulse 10 cycles into a mult → all outputs 0 immediately, no `Pronto`. Then add A=2, B=3 → `Resultado`=5 one cycle later.
- Opcode 111111 → `Invalido`=1, `Resultado`=0, `Pronto` one cycle. Next valid op clears `Invalido`.
